boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 113 +++++++++++
 tb/tb_boot_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Streaming boot loader: receives a word count and that many big-endian words over a
// byte interface, writes them to instruction memory, then releases the CPU from reset.
module boot_loader #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);
    localparam int IDX_W = $clog2(MEM_DEPTH + 1);

    typedef enum logic [2:0] {HDR, LOAD, WRITE, RUN, ERR} state_t;

    state_t             state_reg;
    logic [1:0]         byte_cnt_reg;
    logic [IDX_W-1:0]   word_idx_reg;
    logic [31:0]        n_words_reg;
    logic [31:0]        asm_reg;

    logic [31:0]        shifted;
    logic               take;
    logic [IDX_W-1:0]   idx_inc;

    assign shifted    = {asm_reg[23:0], rx_data};
    assign take       = rx_valid & rx_ready;
    assign idx_inc    = word_idx_reg + 1'b1;
    assign imem_addr  = 32'(word_idx_reg) << 2;
    assign imem_wdata = asm_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= HDR;
            byte_cnt_reg <= 2'd0;
            word_idx_reg <= '0;
            n_words_reg  <= 32'd0;
            asm_reg      <= 32'd0;
            rx_ready     <= 1'b1;
            imem_we      <= 1'b0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            case (state_reg)
                HDR: begin
                    if (take) begin
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        asm_reg      <= shifted;
                        if (byte_cnt_reg == 2'd3) begin
                            n_words_reg <= shifted;
                            if (shifted == 32'd0) begin
                                state_reg <= RUN;
                                rx_ready  <= 1'b0;
                                cpu_reset <= 1'b0;
                                done      <= 1'b1;
                            end else if (shifted > 32'(MEM_DEPTH)) begin
                                state_reg <= ERR;
                                rx_ready  <= 1'b0;
                                error     <= 1'b1;
                            end else begin
                                state_reg <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (take) begin
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        asm_reg      <= shifted;
                        // Only a complete word ever reaches WRITE.
                        if (byte_cnt_reg == 2'd3) begin
                            state_reg <= WRITE;
                            rx_ready  <= 1'b0;
                            imem_we   <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    imem_we      <= 1'b0;
                    word_idx_reg <= idx_inc;
                    if (32'(idx_inc) == n_words_reg) begin
                        state_reg <= RUN;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state_reg <= LOAD;
                        rx_ready  <= 1'b1;
                    end
                end
                RUN, ERR: begin
                    rx_ready <= 1'b0;
                    imem_we  <= 1'b0;
                end
                default: begin
                    state_reg    <= HDR;
                    byte_cnt_reg <= 2'd0;
                    rx_ready     <= 1'b1;
                    imem_we      <= 1'b0;
                    cpu_reset    <= 1'b1;
                    done         <= 1'b0;
                    error        <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: drives byte streams with held, toggling or
// random rx_valid and compares recorded memory writes against expectations.
module tb_boot_loader;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int checks = 0;
    int failures = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    boot_loader #(.MEM_DEPTH(1024)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Each write strobe lasts one cycle, so one negedge sample records it once.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        reset = 1'b0;
    endtask

    // mode 0: rx_valid held, 1: toggling, 2: random. Starts and ends on a negedge.
    task automatic run_stream(input bq_t bytes, input int mode, output int edges);
        int idx = 0;
        logic v, rdy;
        edges = 0;
        while (idx < bytes.size() && edges < 20000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (edges % 2 == 0) : 1'($urandom_range(0, 1));
            rx_valid = v;
            rx_data = v ? bytes[idx] : 8'($urandom);
            rdy = rx_ready;
            @(posedge clk);
            edges++;
            if (v && rdy) idx++;
            @(negedge clk);
            if (done || error) break;
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_term(output int extra);
        extra = 0;
        while (!(done || error) && extra < 50) begin
            @(negedge clk);
            extra++;
        end
    endtask

    function automatic bq_t word_bytes(input logic [31:0] w);
        bq_t q;
        q = {w[31:24], w[23:16], w[15:8], w[7:0]};
        return q;
    endfunction

    task automatic test_reset();
        bq_t s;
        int e;
        checks++;
        if ({rx_ready, imem_we, cpu_reset, done, error} !== 5'b10100) begin
            failures++;
            $display("FAIL reset_initial: got rdy/we/cpu_rst/done/err=%b need 10100",
                     {rx_ready, imem_we, cpu_reset, done, error});
        end
        apply_reset();
        s = {8'h00, 8'h00, 8'h00, 8'h00};
        run_stream(s, 0, e);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({rx_ready, imem_we, cpu_reset, done, error} !== 5'b10100) begin
            failures++;
            $display("FAIL reset_async: got rdy/we/cpu_rst/done/err=%b need 10100",
                     {rx_ready, imem_we, cpu_reset, done, error});
        end
        $display("reset: async assertion from RUN observed done=%b cpu_reset=%b", done, cpu_reset);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_two_words();
        bq_t s;
        int e, x;
        apply_reset();
        s = {8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        run_stream(s, 0, e);
        wait_term(x);
        checks++;
        if (wr_addr.size() != 2) begin
            failures++;
            $display("FAIL two_words_count: got %0d writes need 2", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h20080005) begin
                failures++;
                $display("FAIL two_words_w0: got %h/%h need 00000000/20080005", wr_addr[0], wr_data[0]);
            end
            checks++;
            if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h01095020) begin
                failures++;
                $display("FAIL two_words_w1: got %h/%h need 00000004/01095020", wr_addr[1], wr_data[1]);
            end
        end
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL two_words_run: got done=%b cpu_reset=%b error=%b need 1/0/0", done, cpu_reset, error);
        end
        checks++;
        if (e + x < 14) begin
            failures++;
            $display("FAIL two_words_cycles: got %0d cycles need at least 14", e + x);
        end
        $display("two_words: N=2 writes=%0d cycles=%0d", wr_addr.size(), e + x);
        // Terminal RUN ignores further traffic.
        rx_valid = 1'b1;
        repeat (6) begin
            rx_data = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        checks++;
        if (wr_addr.size() != 2 || rx_ready !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL run_terminal: got writes=%0d rx_ready=%b done=%b need 2/0/1",
                     wr_addr.size(), rx_ready, done);
        end
    endtask

    task automatic test_zero();
        bq_t s;
        int e;
        apply_reset();
        s = {8'h00, 8'h00, 8'h00, 8'h00};
        run_stream(s, 0, e);
        checks++;
        if (e != 4 || done !== 1'b1 || cpu_reset !== 1'b0 || wr_addr.size() != 0) begin
            failures++;
            $display("FAIL zero_header: got edges=%0d done=%b cpu_reset=%b writes=%0d need 4/1/0/0",
                     e, done, cpu_reset, wr_addr.size());
        end
        $display("zero: N=0 edges=%0d done=%b", e, done);
    endtask

    task automatic test_overflow();
        bq_t s;
        int e;
        logic [31:0] ns[2];
        ns[0] = 32'h0000_0401;
        ns[1] = 32'h8000_0001;
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            s = word_bytes(ns[k]);
            for (int i = 0; i < 8; i++) s.push_back(8'($urandom));
            run_stream(s, 0, e);
            repeat (6) @(negedge clk);
            checks++;
            if (error !== 1'b1 || cpu_reset !== 1'b1 || rx_ready !== 1'b0 || done !== 1'b0
                || wr_addr.size() != 0) begin
                failures++;
                $display("FAIL overflow_%0d: got err=%b cpu_rst=%b rdy=%b done=%b writes=%0d need 1/1/0/0/0",
                         k, error, cpu_reset, rx_ready, done, wr_addr.size());
            end
            $display("overflow: N=%h error=%b", ns[k], error);
        end
    endtask

    task automatic test_toggle();
        bq_t s;
        int e, x;
        logic [31:0] w;
        apply_reset();
        w = $urandom;
        s = {8'h00, 8'h00, 8'h00, 8'h01};
        s = {s, word_bytes(w)};
        run_stream(s, 1, e);
        wait_term(x);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== w || done !== 1'b1) begin
            failures++;
            $display("FAIL toggle: got writes=%0d first=%h/%h done=%b need 1 write 00000000/%h done=1",
                     wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 32'hx,
                     (wr_data.size() > 0) ? wr_data[0] : 32'hx, done, w);
        end
        $display("toggle: N=1 word=%h writes=%0d", w, wr_addr.size());
    endtask

    task automatic test_mid_reset();
        bq_t s;
        int e, x;
        apply_reset();
        s = {8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34};
        run_stream(s, 0, e);
        apply_reset();
        checks++;
        if (rx_ready !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_state: got rdy=%b done=%b cpu_rst=%b err=%b need 1/0/1/0",
                     rx_ready, done, cpu_reset, error);
        end
        s = {8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_stream(s, 0, e);
        wait_term(x);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hAABBCCDD || done !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_load: got writes=%0d first=%h/%h done=%b need 1 write 00000000/aabbccdd done=1",
                     wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 32'hx,
                     (wr_data.size() > 0) ? wr_data[0] : 32'hx, done);
        end
        $display("mid_reset: writes=%0d done=%b", wr_addr.size(), done);
    endtask

    // Reference: word i of the stream lands at byte address 4*i, in stream order.
    task automatic test_random(input int n, input int mode);
        bq_t s;
        logic [31:0] words[$];
        int e, x, bad;
        apply_reset();
        s = word_bytes(32'(n));
        for (int i = 0; i < n; i++) begin
            words.push_back($urandom);
            s = {s, word_bytes(words[i])};
        end
        run_stream(s, mode, e);
        wait_term(x);
        checks++;
        if (wr_addr.size() != n) begin
            failures++;
            $display("FAIL random_count: N=%0d got %0d writes", n, wr_addr.size());
        end else begin
            bad = 0;
            for (int i = 0; i < n; i++)
                if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== words[i]) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL random_data: N=%0d got %0d bad writes need 0", n, bad);
            end
        end
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0 || e + x < 5 * n + 4) begin
            failures++;
            $display("FAIL random_run: N=%0d got done=%b cpu_rst=%b err=%b cycles=%0d need 1/0/0 >=%0d",
                     n, done, cpu_reset, error, e + x, 5 * n + 4);
        end
        $display("random: N=%0d mode=%0d writes=%0d cycles=%0d", n, mode, wr_addr.size(), e + x);
    endtask

    initial begin
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        #3;
        test_reset();
        test_two_words();
        test_zero();
        test_overflow();
        test_toggle();
        test_mid_reset();
        for (int k = 0; k < 6; k++) test_random($urandom_range(1, 8), 2);
        test_random(1024, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
